block_scheduler: RTL and testbench

BLOCK_SCHEDULER -- requirements
Module: block_scheduler

---
 rtl/sched_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/block_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_block_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared state encodings and width helpers for the block scheduler slice.
package sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_DISPATCH = 2'd2,
    ST_DRAIN    = 2'd3
  } sched_state_e;

  typedef enum logic [1:0] {
    CORE_FREE    = 2'd0,
    CORE_RUNNING = 2'd1,
    CORE_RECOVER = 2'd2
  } core_state_e;

  localparam int unsigned CNT_W_DEFAULT = 32'd8;
  localparam int unsigned CNT_W_MIN     = 32'd8;
  localparam int unsigned CNT_W_MAX     = 32'd16;

  // Index width for n items; a single item still needs one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts just after the last grant.
module rr_arbiter
  import sched_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  localparam int unsigned IW = idx_width(N);

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] grant_idx_s;
  logic [IW-1:0] cand_s;

  // Scan requesters starting at the pointer; the first one found wins
  always_comb begin
    grant       = {N{1'b0}};
    grant_valid = 1'b0;
    grant_idx_s = {IW{1'b0}};
    cand_s      = {IW{1'b0}};
    for (int k = 0; k < N; k++) begin
      cand_s = IW'((int'(ptr_r) + k) % int'(N));
      if (!grant_valid && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        grant_valid   = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_valid   = grant_valid;
      end
    end
  end

  // Priority pointer moves to the core after the granted one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {IW{1'b0}};
    end else if (grant_valid) begin
      if (int'(grant_idx_s) == int'(N) - 1) begin
        ptr_r <= {IW{1'b0}};
      end else begin
        ptr_r <= grant_idx_s + IW'(1'b1);
      end
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// Kernel block scheduler: splits a thread count into fixed-size blocks and
// hands them to free compute cores, tracking completion and core recovery.
module block_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned NUM_CORES         = 4,
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned CNT_W             = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CNT_W-1:0]           thread_count,
  input  logic [NUM_CORES-1:0]       core_done,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES-1:0]       core_reset,
  output logic [NUM_CORES*CNT_W-1:0] core_block_id,
  output logic [NUM_CORES*CNT_W-1:0] core_thread_count,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           blocks_done
);

  localparam int unsigned    LOG2_TPB = $clog2(THREADS_PER_BLOCK);
  localparam logic [CNT_W:0] TPB_M1   = (CNT_W+1)'(THREADS_PER_BLOCK - 1);
  localparam logic [CNT_W:0] ONE_W1   = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TPB_CNT = CNT_W'(THREADS_PER_BLOCK);

  sched_state_e        state_r;
  core_state_e         core_st_r [NUM_CORES];
  logic [CNT_W-1:0]    tc_r;
  logic [CNT_W:0]      total_r;
  logic [CNT_W:0]      next_r;

  logic [NUM_CORES-1:0] ack_s;
  logic [NUM_CORES-1:0] eligible_s;
  logic [NUM_CORES-1:0] req_s;
  logic [NUM_CORES-1:0] grant_s;
  logic                 grant_valid_s;
  logic [CNT_W-1:0]     ack_cnt_s;
  logic [CNT_W:0]       total_calc_s;
  logic [CNT_W-1:0]     last_count_s;
  logic [CNT_W-1:0]     issue_count_s;
  logic                 issue_last_s;

  // Completions, eligible cores and the request vector for this cycle
  always_comb begin
    ack_s      = core_done & core_start;
    ack_cnt_s  = {CNT_W{1'b0}};
    eligible_s = {NUM_CORES{1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      ack_cnt_s     = ack_cnt_s + CNT_W'(ack_s[i]);
      eligible_s[i] = (core_st_r[i] == CORE_FREE) && !core_reset[i];
    end
    if ((state_r == ST_DISPATCH) && (next_r < total_r) && !abort) begin
      req_s = eligible_s;
    end else begin
      req_s = {NUM_CORES{1'b0}};
    end
  end

  // Block count with one spare bit so the largest thread count cannot wrap
  always_comb begin
    total_calc_s = ({1'b0, tc_r} + TPB_M1) >> LOG2_TPB;
    last_count_s = tc_r - (next_r[CNT_W-1:0] << LOG2_TPB);
    issue_last_s = ((next_r + ONE_W1) == total_r);
    if (issue_last_s) begin
      issue_count_s = last_count_s;
    end else begin
      issue_count_s = TPB_CNT;
    end
  end

  rr_arbiter #(
    .N (NUM_CORES)
  ) u_rr (
    .clk         (clk),
    .rst_n       (reset),
    .req         (req_s),
    .grant       (grant_s),
    .grant_valid (grant_valid_s)
  );

  // Kernel FSM with per-core issue, completion and one-cycle recovery
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r           <= ST_IDLE;
      tc_r              <= {CNT_W{1'b0}};
      total_r           <= {(CNT_W+1){1'b0}};
      next_r            <= {(CNT_W+1){1'b0}};
      core_start        <= {NUM_CORES{1'b0}};
      core_reset        <= {NUM_CORES{1'b1}};
      core_block_id     <= {(NUM_CORES*CNT_W){1'b0}};
      core_thread_count <= {(NUM_CORES*CNT_W){1'b0}};
      busy              <= 1'b0;
      done              <= 1'b0;
      blocks_done       <= {CNT_W{1'b0}};
      for (int i = 0; i < NUM_CORES; i++) begin
        core_st_r[i] <= CORE_FREE;
      end
    end else begin
      done <= 1'b0;
      if (abort && (state_r != ST_IDLE)) begin
        state_r    <= ST_IDLE;
        busy       <= 1'b0;
        core_start <= {NUM_CORES{1'b0}};
        core_reset <= {NUM_CORES{1'b1}};
        for (int i = 0; i < NUM_CORES; i++) begin
          core_st_r[i] <= CORE_FREE;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              tc_r    <= thread_count;
              busy    <= 1'b1;
              state_r <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            total_r     <= total_calc_s;
            next_r      <= {(CNT_W+1){1'b0}};
            blocks_done <= {CNT_W{1'b0}};
            core_start  <= {NUM_CORES{1'b0}};
            core_reset  <= {NUM_CORES{1'b0}};
            for (int i = 0; i < NUM_CORES; i++) begin
              core_st_r[i] <= CORE_FREE;
            end
            if (total_calc_s == {(CNT_W+1){1'b0}}) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= ST_DISPATCH;
            end
          end
          ST_DISPATCH, ST_DRAIN: begin
            for (int i = 0; i < NUM_CORES; i++) begin
              case (core_st_r[i])
                CORE_RUNNING: begin
                  if (ack_s[i]) begin
                    core_start[i] <= 1'b0;
                    core_reset[i] <= 1'b1;
                    core_st_r[i]  <= CORE_RECOVER;
                  end
                end
                CORE_RECOVER: begin
                  core_reset[i] <= 1'b0;
                  core_st_r[i]  <= CORE_FREE;
                end
                CORE_FREE: begin
                  if (grant_s[i]) begin
                    core_start[i]                        <= 1'b1;
                    core_block_id[i*CNT_W +: CNT_W]      <= next_r[CNT_W-1:0];
                    core_thread_count[i*CNT_W +: CNT_W]  <= issue_count_s;
                    core_st_r[i]                         <= CORE_RUNNING;
                  end
                end
                default: core_st_r[i] <= CORE_FREE;
              endcase
            end
            blocks_done <= blocks_done + ack_cnt_s;
            if (grant_valid_s) begin
              next_r <= next_r + ONE_W1;
              if (issue_last_s) begin
                state_r <= ST_DRAIN;
              end
            end
            // Completion is judged on the registered count, so done trails it by a cycle
            if ((state_r == ST_DRAIN) && ({1'b0, blocks_done} == total_r)) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench: a 4-core instance driven by hand, a 2-core instance with
// cores that acknowledge five cycles after each block starts.
module tb_block_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start4, abort4;
  logic [7:0]  tc4;
  logic [3:0]  cdone4;
  logic [3:0]  cstart4, creset4;
  logic [31:0] bid4, tcnt4;
  logic        busy4, done4;
  logic [7:0]  bdone4;

  logic        start2, abort2;
  logic [7:0]  tc2;
  logic [1:0]  cdone2 = 2'b00;
  logic [1:0]  cstart2, creset2;
  logic [15:0] bid2, tcnt2;
  logic        busy2, done2;
  logic [7:0]  bdone2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] q_id[$];
  logic [7:0] q_cnt[$];
  int         q_cyc[$];
  int         ack_cnt[2];
  logic [1:0] prev2 = 2'b00;

  block_scheduler #(.NUM_CORES(4), .THREADS_PER_BLOCK(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .abort(abort4), .thread_count(tc4),
    .core_done(cdone4), .core_start(cstart4), .core_reset(creset4),
    .core_block_id(bid4), .core_thread_count(tcnt4),
    .busy(busy4), .done(done4), .blocks_done(bdone4));

  block_scheduler #(.NUM_CORES(2), .THREADS_PER_BLOCK(4), .CNT_W(8)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2), .thread_count(tc2),
    .core_done(cdone2), .core_start(cstart2), .core_reset(creset2),
    .core_block_id(bid2), .core_thread_count(tcnt2),
    .busy(busy2), .done(done2), .blocks_done(bdone2));

  always @(posedge clk) cyc <= cyc + 1;

  // Core model for the 2-core instance plus a log of every issued block
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cdone2[i]) begin
        cdone2[i]  = 1'b0;
        ack_cnt[i] = 0;
      end else if (cstart2[i]) begin
        ack_cnt[i] = ack_cnt[i] + 1;
        if (ack_cnt[i] == 5) cdone2[i] = 1'b1;
      end else begin
        ack_cnt[i] = 0;
      end
      if (cstart2[i] && !prev2[i]) begin
        q_id.push_back(bid2[i*8 +: 8]);
        q_cnt.push_back(tcnt2[i*8 +: 8]);
        q_cyc.push_back(cyc);
      end
    end
    prev2 = cstart2;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run2(input string tag, input logic [7:0] tc, input int bound, output int pulses);
    int k;
    int tail;
    q_id.delete();
    q_cnt.delete();
    q_cyc.delete();
    pulses = 0;
    k      = 0;
    tail   = 0;
    start2 = 1'b1;
    tc2    = tc;
    @(negedge clk);
    start2 = 1'b0;
    while (k < bound && tail < 3) begin
      @(negedge clk);
      k++;
      if (done2) pulses++;
      if (!busy2) tail++;
    end
    check_eq({tag, "_terminated"}, 32'(tail), 32'd3);
  endtask

  initial begin
    int pulses;
    int bad;
    reset = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; tc4 = 8'd0; cdone4 = 4'd0;
    start2 = 1'b0; abort2 = 1'b0; tc2 = 8'd0;
    tick(2);
    check_eq("rst_core_reset4", 32'(creset4), 32'hF);
    check_eq("rst_core_reset2", 32'(creset2), 32'h3);
    check_eq("rst_core_start", 32'(cstart4), 32'h0);
    check_eq("rst_block_id", bid4, 32'h0);
    check_eq("rst_thread_cnt", tcnt4, 32'h0);
    check_eq("rst_busy", 32'(busy4), 32'd0);
    check_eq("rst_done", 32'(done4), 32'd0);
    check_eq("rst_blocks_done", 32'(bdone4), 32'd0);
    reset = 1'b1;
    tick(2);

    // zero threads: done two cycles after start, no core started
    start4 = 1'b1; tc4 = 8'd0; tick(1); start4 = 1'b0;
    check_eq("zero_busy", 32'(busy4), 32'd1);
    check_eq("zero_done_early", 32'(done4), 32'd0);
    tick(1);
    check_eq("zero_done", 32'(done4), 32'd1);
    check_eq("zero_busy_off", 32'(busy4), 32'd0);
    check_eq("zero_no_start", 32'(cstart4), 32'h0);
    check_eq("zero_reset_rel", 32'(creset4), 32'h0);
    tick(1);
    check_eq("zero_done_pulse", 32'(done4), 32'd0);

    // 16 threads on 4 cores, all complete together
    start4 = 1'b1; tc4 = 8'd16; tick(1); start4 = 1'b0; tick(2);
    check_eq("t16_first_start", 32'(cstart4), 32'h1);
    check_eq("t16_first_id", 32'(bid4[7:0]), 32'd0);
    check_eq("t16_first_cnt", 32'(tcnt4[7:0]), 32'd4);
    tick(3);
    check_eq("t16_all_start", 32'(cstart4), 32'hF);
    check_eq("t16_ids", bid4, 32'h03020100);
    check_eq("t16_cnts", tcnt4, 32'h04040404);
    check_eq("t16_bd0", 32'(bdone4), 32'd0);
    cdone4 = 4'hF; tick(1); cdone4 = 4'h0;
    check_eq("t16_bd4", 32'(bdone4), 32'd4);
    check_eq("t16_start_clr", 32'(cstart4), 32'h0);
    check_eq("t16_recover", 32'(creset4), 32'hF);
    check_eq("t16_no_done_yet", 32'(done4), 32'd0);
    tick(1);
    check_eq("t16_done", 32'(done4), 32'd1);
    check_eq("t16_idle", 32'(busy4), 32'd0);
    check_eq("t16_reset_rel", 32'(creset4), 32'h0);
    tick(1);
    check_eq("t16_done_pulse", 32'(done4), 32'd0);
    check_eq("t16_bd_hold", 32'(bdone4), 32'd4);

    // abort with two blocks running
    start4 = 1'b1; tc4 = 8'd16; tick(1); start4 = 1'b0; tick(3);
    check_eq("abort_pre", 32'(cstart4), 32'h3);
    abort4 = 1'b1; tick(1); abort4 = 1'b0;
    check_eq("abort_start", 32'(cstart4), 32'h0);
    check_eq("abort_reset", 32'(creset4), 32'hF);
    check_eq("abort_busy", 32'(busy4), 32'd0);
    check_eq("abort_no_done", 32'(done4), 32'd0);
    tick(1);
    check_eq("abort_no_done2", 32'(done4), 32'd0);

    // start during DRAIN ignored; stray done from idle core ignored
    start4 = 1'b1; tc4 = 8'd8; tick(1); start4 = 1'b0; tick(3);
    check_eq("drain_start", 32'(cstart4), 32'hC);
    check_eq("drain_id2", 32'(bid4[23:16]), 32'd0);
    check_eq("drain_id3", 32'(bid4[31:24]), 32'd1);
    check_eq("drain_cnt3", 32'(tcnt4[31:24]), 32'd4);
    start4 = 1'b1; tc4 = 8'd20; tick(1); start4 = 1'b0;
    check_eq("drain_busy", 32'(busy4), 32'd1);
    check_eq("drain_start_kept", 32'(cstart4), 32'hC);
    cdone4 = 4'h5; tick(1);
    check_eq("drain_bd1", 32'(bdone4), 32'd1);
    check_eq("drain_start_c2", 32'(cstart4), 32'h8);
    check_eq("drain_reset_c2", 32'(creset4), 32'h4);
    cdone4 = 4'h8; tick(1); cdone4 = 4'h0;
    check_eq("drain_bd2", 32'(bdone4), 32'd2);
    check_eq("drain_no_done", 32'(done4), 32'd0);
    check_eq("drain_busy2", 32'(busy4), 32'd1);
    tick(1);
    check_eq("drain_done", 32'(done4), 32'd1);
    check_eq("drain_idle", 32'(busy4), 32'd0);
    tick(1);
    check_eq("drain_done_pulse", 32'(done4), 32'd0);

    // next kernel takes the thread count present at its own start
    start4 = 1'b1; tc4 = 8'd10; tick(1); start4 = 1'b0; tick(4);
    check_eq("tc10_starts", 32'(cstart4), 32'h7);
    check_eq("tc10_last_id", 32'(bid4[23:16]), 32'd2);
    check_eq("tc10_last_cnt", 32'(tcnt4[23:16]), 32'd2);
    check_eq("tc10_mid_cnt", 32'(tcnt4[15:8]), 32'd4);
    tick(1);
    check_eq("tc10_no_more", 32'(cstart4), 32'h7);
    abort4 = 1'b1; tick(1); abort4 = 1'b0;
    check_eq("tc10_abort_busy", 32'(busy4), 32'd0);
    check_eq("tc10_abort_start", 32'(cstart4), 32'h0);

    // 2 cores, 10 threads, acknowledged after 5 cycles
    run2("k10", 8'd10, 200, pulses);
    check_eq("k10_done_once", 32'(pulses), 32'd1);
    check_eq("k10_blocks_done", 32'(bdone2), 32'd3);
    check_eq("k10_issues", 32'(q_id.size()), 32'd3);
    if (q_id.size() == 3) begin
      check_eq("k10_id0", 32'(q_id[0]), 32'd0);
      check_eq("k10_id1", 32'(q_id[1]), 32'd1);
      check_eq("k10_id2", 32'(q_id[2]), 32'd2);
      check_eq("k10_cnt0", 32'(q_cnt[0]), 32'd4);
      check_eq("k10_cnt1", 32'(q_cnt[1]), 32'd4);
      check_eq("k10_cnt2", 32'(q_cnt[2]), 32'd2);
      check_eq("k10_back_to_back", 32'(q_cyc[1] - q_cyc[0]), 32'd1);
      check_eq("k10_reissue_gap", 32'(q_cyc[2] - q_cyc[0]), 32'd7);
    end

    // maximum thread count: 64 blocks, final block of 3
    run2("k255", 8'd255, 3000, pulses);
    check_eq("k255_done_once", 32'(pulses), 32'd1);
    check_eq("k255_blocks_done", 32'(bdone2), 32'd64);
    check_eq("k255_issues", 32'(q_id.size()), 32'd64);
    if (q_id.size() == 64) begin
      bad = 0;
      for (int i = 0; i < 63; i++) begin
        if (q_id[i] != 8'(i) || q_cnt[i] != 8'd4) bad++;
      end
      check_eq("k255_fields", 32'(bad), 32'd0);
      check_eq("k255_last_id", 32'(q_id[63]), 32'd63);
      check_eq("k255_last_cnt", 32'(q_cnt[63]), 32'd3);
    end

    // reset mid-kernel discards everything immediately
    start4 = 1'b1; tc4 = 8'd16; tick(1); start4 = 1'b0; tick(3);
    check_eq("midrst_pre", 32'(cstart4), 32'h9);
    reset = 1'b0;
    #1;
    check_eq("midrst_start", 32'(cstart4), 32'h0);
    check_eq("midrst_reset", 32'(creset4), 32'hF);
    check_eq("midrst_busy", 32'(busy4), 32'd0);
    check_eq("midrst_ids", bid4, 32'h0);
    tick(1);
    reset = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
